wb_regfile: RTL
===============

Name: wb_regfile

Overview:
Architectural register file that sits at the far end of the pipeline's writeback interface. It accepts the writeback bundle (RFWr, MDIV, RDst, RWD) produced by the WB stage and commits it to the 32 x 32-bit GPR array or the HI/LO pair. It serves two combinational GPR read ports to ID, plus HI/LO reads. Same-cycle writes are forwarded to the read ports, so ID never sees stale data from an instruction retiring in the same cycle.

Parameters:
GPR_NUM, 32, number of general-purpose registers; index width is fixed at 5.
DBG_EN, 1, enables the debug read port; when 0, DbgRD is tied to 0.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-low; clears all architectural state.
RFWr  in  1  writeback valid/strobe from WB.
MDIV  in  1  writeback target select: 1 = HI/LO pair, 0 = GPR.
RDst  in  5  destination GPR index; ignored when MDIV=1.
RWD  in  64  writeback data; GPR writes use [31:0]; HI/LO writes use [63:32]/[31:0].
A1  in  5  read port 1 address.
A2  in  5  read port 2 address.
RD1  out  32  read port 1 data.
RD2  out  32  read port 2 data.
HI  out  32  HI register value, with bypass.
LO  out  32  LO register value, with bypass.
DbgA  in  5  debug read address.
DbgRD  out  32  debug read data; raw array value, no bypass.
WrCnt  out  16  count of committed writes.

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - GPR[0..31] = 0; HI = 0; LO = 0; WrCnt = 0.
  - RD1/RD2/DbgRD therefore read 0.
  - A write strobe coincident with an active reset is dropped.
  - Deasserting rst mid-operation resumes normally on the next edge.
- GPR commit, on the rising edge when RFWr=1 and MDIV=0:
  - GPR[RDst] <= RWD[31:0].
  - RDst=0 is discarded; GPR[0] stays 0.
  - RWD[63:32] is ignored.
- HI/LO commit, on the rising edge when RFWr=1 and MDIV=1:
  - HI <= RWD[63:32] and LO <= RWD[31:0], atomically.
  - No GPR is modified, regardless of RDst.
- RFWr=0: no state change; MDIV, RDst and RWD are don't-care.
- Read ports are combinational, zero latency:
  - RDn = 0 if An=0.
  - Otherwise RDn = RWD[31:0] if (RFWr & ~MDIV & RDst==An).
  - Otherwise RDn = GPR[An].
  - Both ports may hit the same address, or the write address, simultaneously; each resolves independently.
- HI/LO outputs:
  - If (RFWr & MDIV): HI = RWD[63:32], LO = RWD[31:0] (bypass).
  - Otherwise HI/LO show the stored values.
- Write counter:
  - WrCnt increments by 1 on each committed write.
  - A GPR write to RDst=0 does not count; an HI/LO write counts once.
  - Wraps 0xFFFF -> 0x0000 with no saturation or flag.
- Storage is flip-flop based, not RAM inference, so asynchronous reset of the whole array is legal.
- No X propagation:
  - Out-of-range reads cannot occur (5-bit index with GPR_NUM=32).
  - If GPR_NUM<32, reads beyond range return 0 and writes beyond range are dropped.

Test Plan:
1. Hold rst=0 for 2 cycles, release -> RD1=RD2=HI=LO=WrCnt=0 for all A1/A2 values 0..31.
2. RFWr=1, MDIV=0, RDst=8, RWD=0xDEADBEEF_12345678, A1=8 in the same cycle -> RD1=0x12345678 before the edge (bypass); after the edge with RFWr=0, RD1=0x12345678 and WrCnt=1.
3. RFWr=1, MDIV=0, RDst=0, RWD=0xFFFFFFFF, A1=0 -> RD1=0 before and after the edge; WrCnt unchanged.
4. RFWr=1, MDIV=1, RDst=8, RWD=0x00000001_80000000 -> HI=0x00000001, LO=0x80000000 in the same cycle; GPR[8] unchanged; WrCnt +1.
5. Write 0x0000AAAA to $5; next cycle write 0x0000BBBB to $5 with A1=A2=5 -> RD1=RD2=0x0000BBBB during the second write cycle; DbgA=5 returns 0x0000AAAA until the edge.
6. Preload WrCnt to 0xFFFF via 65535 writes, then one more write -> WrCnt=0x0000. Then assert rst asynchronously mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback-side register file: 32x32 GPRs plus HI/LO, commits on the rising edge, with zero-latency combinational reads.
// Same-cycle writes are bypassed to RD1/RD2/HI/LO; there is no backpressure, and every strobe is accepted.
module wb_regfile #(
    parameter int GPR_NUM = 32,
    parameter bit DBG_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RFWr,
    input  logic        MDIV,
    input  logic [4:0]  RDst,
    input  logic [63:0] RWD,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic [31:0] HI,
    output logic [31:0] LO,
    input  logic [4:0]  DbgA,
    output logic [31:0] DbgRD,
    output logic [15:0] WrCnt
);

    logic [31:0] gpr [32];
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [15:0] cnt_q;

    logic gpr_strobe;
    logic gpr_commit;
    logic hilo_commit;

    function automatic logic in_range(input logic [4:0] a);
        return ({27'd0, a} < GPR_NUM);
    endfunction

    assign gpr_strobe  = RFWr & ~MDIV;
    assign gpr_commit  = gpr_strobe & (RDst != 5'd0) & in_range(RDst);
    assign hilo_commit = RFWr & MDIV;

    // Entries at or beyond GPR_NUM are never written, so they stay at their reset value of 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= '0;
            end
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (gpr_commit) begin
                gpr[RDst] <= RWD[31:0];
            end
            if (hilo_commit) begin
                hi_q <= RWD[63:32];
                lo_q <= RWD[31:0];
            end
            if (gpr_commit || hilo_commit) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        RD1 = '0;
        if (A1 != 5'd0 && in_range(A1)) begin
            RD1 = (gpr_strobe && RDst == A1) ? RWD[31:0] : gpr[A1];
        end
    end

    always_comb begin
        RD2 = '0;
        if (A2 != 5'd0 && in_range(A2)) begin
            RD2 = (gpr_strobe && RDst == A2) ? RWD[31:0] : gpr[A2];
        end
    end

    always_comb begin
        DbgRD = '0;
        if (DBG_EN && in_range(DbgA)) begin
            DbgRD = gpr[DbgA];
        end
    end

    assign HI    = hilo_commit ? RWD[63:32] : hi_q;
    assign LO    = hilo_commit ? RWD[31:0]  : lo_q;
    assign WrCnt = cnt_q;

endmodule
